add_image_hls_deadlock_report_ctrl: RTL and testbench



---
 rtl/add_image_hls_dl_pkg.sv | 25 ++
 rtl/add_image_hls_dl_prio_enc.sv | 31 +++
 rtl/add_image_hls_deadlock_report_ctrl.sv | 122 ++++++++++++
 tb/tb_add_image_hls_deadlock_report_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/add_image_hls_dl_pkg.sv
// ============================================================================
// Module  : add_image_hls_dl_pkg
// Brief   : Shared constants for the add_image HLS deadlock report controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package add_image_hls_dl_pkg;

    localparam int DL_PROC_NUM      = 4;
    localparam int DL_TRACE_TIMEOUT = 64;
    localparam int DL_ID_W          = (DL_PROC_NUM > 1) ? $clog2(DL_PROC_NUM) : 1;
    // One extra bit so the counter can hold TRACE_TIMEOUT itself.
    localparam int DL_CNT_W         = $clog2(DL_TRACE_TIMEOUT) + 1;

    localparam int         DL_STATE_W = 3;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ORIGIN  = 3'd1;
    localparam logic [2:0] ST_TRACE   = 3'd2;
    localparam logic [2:0] ST_CLEAR   = 3'd3;
    localparam logic [2:0] ST_REPORT  = 3'd4;

endpackage : add_image_hls_dl_pkg

`default_nettype wire

// File: rtl/add_image_hls_dl_prio_enc.sv
// ============================================================================
// Module  : add_image_hls_dl_prio_enc
// Brief   : Lowest-index priority encoder with any-valid flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_image_hls_dl_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule : add_image_hls_dl_prio_enc

`default_nettype wire

// File: rtl/add_image_hls_deadlock_report_ctrl.sv
// ============================================================================
// Module  : add_image_hls_deadlock_report_ctrl
// Brief   : Freezes the dependence network on deadlock, traces the report
//           token around the wait-for cycle and latches a deadlock report.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_image_hls_deadlock_report_ctrl
    import add_image_hls_dl_pkg::*;
#(
    parameter int PROC_NUM      = DL_PROC_NUM,
    parameter int ID_W          = DL_ID_W,
    parameter int TRACE_TIMEOUT = DL_TRACE_TIMEOUT,
    parameter int CNT_W         = DL_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    output logic                dl_detect_in,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                report_valid,
    output logic [ID_W-1:0]     report_origin,
    output logic [PROC_NUM-1:0] report_mask,
    output logic [CNT_W-1:0]    report_hops,
    output logic                report_timeout,
    input  logic                report_ack
);

    localparam logic [PROC_NUM-1:0] C_ONE          = PROC_NUM'(1);
    localparam logic [CNT_W-1:0]    C_TIMEOUT_LAST = CNT_W'(TRACE_TIMEOUT - 1);

    logic [DL_STATE_W-1:0] r_state;
    logic [ID_W-1:0]       r_orig_id;
    logic [PROC_NUM-1:0]   r_mask;
    logic [CNT_W-1:0]      r_hops;
    logic [CNT_W-1:0]      r_timer;
    logic                  r_timeout;

    logic [ID_W-1:0]       w_first_id;
    logic                  w_any;
    logic [PROC_NUM-1:0]   w_orig_onehot;
    logic                  w_returned;
    logic                  w_other;

    add_image_hls_dl_prio_enc #(
        .N     (PROC_NUM),
        .IDX_W (ID_W)
    ) u_prio_enc (
        .i_vec   (dl_detect_vec),
        .o_idx   (w_first_id),
        .o_valid (w_any)
    );

    assign w_orig_onehot = C_ONE << r_orig_id;
    assign w_returned    = |(dl_detect_vec & w_orig_onehot);
    assign w_other       = |(dl_detect_vec & ~w_orig_onehot);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_orig_id <= '0;
            r_mask    <= '0;
            r_hops    <= '0;
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_any) begin
                        r_orig_id <= w_first_id;
                        r_mask    <= C_ONE << w_first_id;
                        r_hops    <= '0;
                        r_timer   <= '0;
                        r_timeout <= 1'b0;
                        r_state   <= ST_ORIGIN;
                    end
                end
                ST_ORIGIN: r_state <= ST_TRACE;
                ST_TRACE: begin
                    r_mask <= r_mask | dl_detect_vec;
                    if (w_other && (r_hops != '1)) begin
                        r_hops <= r_hops + CNT_W'(1);
                    end
                    if (r_timer != '1) begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                    // Token return takes precedence over a coincident timeout.
                    if (w_returned) begin
                        r_timeout <= 1'b0;
                        r_state   <= ST_CLEAR;
                    end else if (r_timer == C_TIMEOUT_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_CLEAR;
                    end
                end
                ST_CLEAR:  r_state <= ST_REPORT;
                ST_REPORT: begin
                    if (report_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; report fields read zero outside REPORT.
    assign dl_detect_in   = (r_state != ST_IDLE);
    assign origin_vec     = (r_state == ST_ORIGIN) ? w_orig_onehot : '0;
    assign token_clear    = (r_state == ST_CLEAR);
    assign report_valid   = (r_state == ST_REPORT);
    assign report_origin  = report_valid ? r_orig_id : '0;
    assign report_mask    = report_valid ? r_mask    : '0;
    assign report_hops    = report_valid ? r_hops    : '0;
    assign report_timeout = report_valid & r_timeout;

endmodule : add_image_hls_deadlock_report_ctrl

`default_nettype wire

// File: tb/tb_add_image_hls_deadlock_report_ctrl.sv
// ============================================================================
// Module  : tb_add_image_hls_deadlock_report_ctrl
// Brief   : Directed self-checking bench with a cycle-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_image_hls_deadlock_report_ctrl;

    localparam int P  = 4;
    localparam int IW = 2;
    localparam int TO = 64;
    localparam int CW = 7;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [P-1:0]  vec = '0;
    logic          ack = 1'b0;
    logic          dl_in;
    logic [P-1:0]  org;
    logic          tclr;
    logic          rvalid;
    logic [IW-1:0] rorig;
    logic [P-1:0]  rmask;
    logic [CW-1:0] rhops;
    logic          rto;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    add_image_hls_deadlock_report_ctrl #(
        .PROC_NUM(P), .ID_W(IW), .TRACE_TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .dl_detect_vec(vec),
        .dl_detect_in(dl_in), .origin_vec(org), .token_clear(tclr),
        .report_valid(rvalid), .report_origin(rorig), .report_mask(rmask),
        .report_hops(rhops), .report_timeout(rto), .report_ack(ack)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 origin pulse, 2 tracing, 3 clear, 4 report.
    int       m_phase   = 0;
    int       m_orig    = 0;
    int       m_mask    = 0;
    int       m_hops    = 0;
    int       m_tcycles = 0;
    bit       m_to      = 1'b0;

    always @(posedge clock) begin
        if (!reset) begin
            m_phase = 0; m_orig = 0; m_mask = 0; m_hops = 0; m_tcycles = 0; m_to = 0;
        end else begin
            case (m_phase)
                0: if (enable && vec != 0) begin
                       m_orig = 0;
                       while (!vec[m_orig]) m_orig++;
                       m_mask = 1 << m_orig; m_hops = 0; m_tcycles = 0; m_to = 0;
                       m_phase = 1;
                   end
                1: m_phase = 2;
                2: begin
                       m_tcycles++;
                       m_mask = m_mask | int'(vec);
                       if ((int'(vec) & ~(1 << m_orig)) != 0 && m_hops < (2**CW - 1)) m_hops++;
                       if (vec[m_orig]) begin
                           m_to = 0; m_phase = 3;
                       end else if (m_tcycles == TO) begin
                           m_to = 1; m_phase = 3;
                       end
                   end
                3: m_phase = 4;
                default: if (ack) m_phase = 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_dl_detect_in", 32'(dl_in),  32'(m_phase != 0));
            chk("m_origin_vec",   32'(org),    (m_phase == 1) ? 32'(1 << m_orig) : 32'd0);
            chk("m_token_clear",  32'(tclr),   32'(m_phase == 3));
            chk("m_report_valid", 32'(rvalid), 32'(m_phase == 4));
            chk("m_report_origin",32'(rorig),  (m_phase == 4) ? 32'(m_orig) : 32'd0);
            chk("m_report_mask",  32'(rmask),  (m_phase == 4) ? 32'(m_mask) : 32'd0);
            chk("m_report_hops",  32'(rhops),  (m_phase == 4) ? 32'(m_hops) : 32'd0);
            chk("m_report_to",    32'(rto),    (m_phase == 4) ? 32'(m_to)   : 32'd0);
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    initial begin
        int cyc;
        step(2);
        chk_en = 1'b1;
        chk("rst_dl_in", 32'(dl_in), 32'd0);
        chk("rst_valid", 32'(rvalid), 32'd0);
        reset = 1'b1;
        step();

        // Basic cycle: origin 1, token visits 2 and 3, then returns.
        enable = 1'b1; vec = 4'b0010; step();
        chk("basic_dl_in", 32'(dl_in), 32'd1);
        chk("basic_origin_vec", 32'(org), 32'h2);
        vec = 4'b0000; step();
        chk("basic_origin_once", 32'(org), 32'h0);
        vec = 4'b0100; step();
        vec = 4'b1000; step();
        vec = 4'b0010; step();
        chk("basic_tclr", 32'(tclr), 32'd1);
        vec = 4'b0000; step();
        chk("basic_origin", 32'(rorig), 32'd1);
        chk("basic_mask", 32'(rmask), 32'hE);
        chk("basic_hops", 32'(rhops), 32'd2);
        chk("basic_to", 32'(rto), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_mask", 32'(rmask), 32'hE);
            chk("hold_dl_in", 32'(dl_in), 32'd1);
        end
        do_ack();
        chk("ack_valid", 32'(rvalid), 32'd0);
        chk("ack_dl_in", 32'(dl_in), 32'd0);

        // Priority: lowest set index wins.
        vec = 4'b1010; step();
        chk("prio_origin_vec", 32'(org), 32'h2);
        vec = 4'b0000; step();
        vec = 4'b0010; step();
        vec = 4'b0000; step();
        chk("prio_origin", 32'(rorig), 32'd1);
        do_ack();

        // Timeout: origin 0 never returns, unit 2 keeps reporting.
        vec = 4'b0001; step();
        vec = 4'b0100;
        cyc = 0;
        while (!tclr && cyc < 200) begin
            step(); cyc++;
        end
        chk("to_origin_to_clear", 32'(cyc), 32'(TO + 1));
        vec = 4'b0000; step();
        chk("to_flag", 32'(rto), 32'd1);
        chk("to_mask", 32'(rmask), 32'h5);
        chk("to_hops", 32'(rhops), 32'(TO));
        do_ack();

        // Return lands on the final allowed trace cycle.
        vec = 4'b0001; step();
        vec = 4'b0000; step();
        step(TO - 1);
        vec = 4'b0001; step();
        chk("tie_tclr", 32'(tclr), 32'd1);
        vec = 4'b0000; step();
        chk("tie_to", 32'(rto), 32'd0);
        chk("tie_mask", 32'(rmask), 32'h1);
        do_ack();

        // Reset in the middle of a trace.
        vec = 4'b0100; step();
        vec = 4'b0000; step(3);
        reset = 1'b0; step();
        chk("mid_rst_dl_in", 32'(dl_in), 32'd0);
        chk("mid_rst_tclr", 32'(tclr), 32'd0);
        reset = 1'b1; enable = 1'b0; step(3);
        chk("mid_rst_valid", 32'(rvalid), 32'd0);

        // Disabled detection is ignored; enabling restarts the sequence.
        vec = 4'b0001; step(3);
        chk("dis_dl_in", 32'(dl_in), 32'd0);
        enable = 1'b1; step();
        chk("en_dl_in", 32'(dl_in), 32'd1);
        enable = 1'b0; vec = 4'b0000; step();
        vec = 4'b0011; step();
        vec = 4'b0000; step();
        chk("en_mask", 32'(rmask), 32'h3);
        chk("en_hops", 32'(rhops), 32'd1);
        do_ack();
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_add_image_hls_deadlock_report_ctrl

`default_nettype wire
